queue_write_arbiter: RTL and testbench
======================================

QUEUE_WRITE_ARBITER -- requirements
Module: queue_write_arbiter

Interface
REQ-001 NUM_REQ, 4, number of requesters sharing one queue write port (2..8).
REQ-002 WIDTH, 32, data word width; equals the downstream queue WIDTH.
REQ-003 MAX_BURST, 4, maximum consecutive grants to one locked requester (1..16).
REQ-004 Clock  in  1  rising-edge clock.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Req  in  NUM_REQ  per-requester write request; held with data until Ack.
REQ-007 Lock  in  NUM_REQ  per-requester burst request; meaningful only while Req of the same bit is high.
REQ-008 Req_Data  in  NUM_REQ*WIDTH  flat data; slice i = bits [i*WIDTH +: WIDTH].
REQ-009 Ack  out  NUM_REQ  one-hot pulse, one cycle; word of requester i captured at this edge.
REQ-010 Q_IsFull  in  1  downstream queue full flag.
REQ-011 Q_Data_In  out  WIDTH  word presented to queue.
REQ-012 Q_InputValid  out  1  word valid to queue; equals out_valid AND NOT Q_IsFull.
REQ-013 Busy  out  1  high while the output register holds a word.

Function
REQ-014 Holding register (out_data, out_valid) shall sit between arbitration and the queue; Q_Data_In = out_data.
REQ-015 Transfer to queue occurs on a cycle where Q_InputValid=1; the queue shall never see InputValid while Q_IsFull=1.
REQ-016 Capture is allowed when out_valid=0 or a transfer occurs in the same cycle (full throughput: one word per cycle).
REQ-017 On capture, winner's slice loads out_data, out_valid=1, Ack[winner]=1 in that same cycle (combinational Ack, registered data).
REQ-018 Latency: Req rising with empty register -> Ack same cycle -> Q_InputValid next cycle if Q_IsFull=0.
REQ-019 Winner selection: round-robin, search starts at (last_winner+1) mod NUM_REQ; last_winner updates only on capture.
REQ-020 State machine ARB (normal round-robin) / BURST (locked owner).
REQ-021 ARB -> BURST when capture occurs with Lock[winner]=1 and MAX_BURST>1; burst_cnt loads 1.
REQ-022 In BURST only the owner may win; each owner capture increments burst_cnt.
REQ-023 BURST -> ARB when owner drops Req or Lock, or at the capture where burst_cnt reaches MAX_BURST; next winner then chosen round-robin after owner.
REQ-024 No capture possible (register full and Q_IsFull=1): Ack=0, state, pointer, burst_cnt unchanged.
REQ-025 Req all zero: no capture; out_valid clears after transfer; Busy follows out_valid.
REQ-026 Requester dropping Req before Ack is legal; its word is simply not captured.
REQ-027 Ack shall be at most one-hot and never asserted for a bit with Req=0.

Reset
REQ-028 Reset shall set out_valid=0, out_data=0, state=ARB, last_winner=NUM_REQ-1 (requester 0 highest priority first), burst_cnt=0.
REQ-029 During Reset Ack=0, Q_InputValid=0, Busy=0; any held word is discarded, no Ack replayed.

Structure
REQ-030 ARB/BURST state encoding and the burst counter width ($clog2(MAX_BURST+1)) shall live in shared package queue_pkg.
REQ-031 Round-robin selection shall be a sub-module rr_select (Req, mask, pointer in; one-hot grant and index out), purely combinational.
REQ-032 Top-level holds the FSM, holding register, counter and pointer; no other sub-modules.

Verification
REQ-033 Reset, then Req=0001 data 0xA -> Ack=0001 cycle 0, Q_InputValid=1 Q_Data_In=0xA cycle 1.
REQ-034 Req=1111 held, Lock=0, Q_IsFull=0 -> Ack sequence 0001,0010,0100,1000,0001, one per cycle.
REQ-035 Register full, Q_IsFull=1 for 5 cycles with Req=0110 -> Ack=0, Q_InputValid=0, Q_Data_In stable; on release one transfer then Ack resumes with round-robin order unchanged.
REQ-036 Req=1111, Lock=0010, MAX_BURST=4 -> requester 1 acked 4 consecutive cycles, then 0100.
REQ-037 Lock owner drops Req after 2 grants -> state returns to ARB, next Ack goes to next requester round-robin.
REQ-038 Reset asserted mid-burst with register full -> next cycle Busy=0, Q_InputValid=0, first post-reset Ack to lowest-index requester.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared definitions for the queue write arbiter: arbitration state encoding
// and the burst counter sizing rule.
package queue_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Counter must be able to hold the value MAX_BURST itself.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/queue_write_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after start_i
// (wrapping) that is both requesting and enabled by mask_i.
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int pos;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(start_i) + k) % N;
            if (!valid_o && req_i[pos] && mask_i[pos]) begin
                valid_o      = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter with locked bursts feeding a single queue write port
// through a one-word holding register.
module queue_write_arbiter
    import queue_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ-1:0]       Lock,
    input  logic [NUM_REQ*WIDTH-1:0] Req_Data,
    output logic [NUM_REQ-1:0]       Ack,
    input  logic                     Q_IsFull,
    output logic [WIDTH-1:0]         Q_Data_In,
    output logic                     Q_InputValid,
    output logic                     Busy,
    output arb_state_e               dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = burst_cnt_w(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;

    logic [IDX_W-1:0]   start_idx, win_idx;
    logic [NUM_REQ-1:0] mask, grant;
    logic               win_valid, room, transfer, burst_hold, capture;

    assign transfer   = valid_q && !Q_IsFull;
    assign room       = !valid_q || !Q_IsFull;
    // In BURST the owner is always the last winner; it keeps the port only
    // while it still asserts both Req and Lock.
    assign burst_hold = (state_q == BURST) && Req[last_q] && Lock[last_q];
    assign start_idx  = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

    always_comb begin
        mask = '1;
        if (burst_hold) begin
            mask         = '0;
            mask[last_q] = 1'b1;
        end
    end

    rr_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req_i   (Req),
        .mask_i  (mask),
        .start_i (start_idx),
        .grant_o (grant),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign capture      = room && win_valid;
    assign Ack          = (capture && !Reset) ? grant : '0;
    assign Q_InputValid = transfer && !Reset;
    assign Busy         = valid_q && !Reset;
    assign Q_Data_In    = data_q;
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (capture) begin
            data_d  = Req_Data[win_idx*WIDTH +: WIDTH];
            valid_d = 1'b1;
            last_d  = win_idx;
            if (burst_hold) begin
                if (cnt_q + 1'b1 == CNT_MAX) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (Lock[win_idx] && (MAX_BURST > 1)) begin
                state_d = BURST;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = ARB;
                cnt_d   = '0;
            end
        end else begin
            if (transfer) begin
                valid_d = 1'b0;
            end
            // Owner released while the port could have taken a word.
            if (room && (state_q == BURST) && !burst_hold) begin
                state_d = ARB;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ARB;
            last_q  <= LAST_IDX;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_queue_write_arbiter.sv
// Bench for queue_write_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the arbiter.
module tb_queue_write_arbiter;
    import queue_pkg::*;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int MAXB = 4;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    logic [N-1:0]   Req = '0;
    logic [N-1:0]   Lock = '0;
    logic [N*W-1:0] Req_Data;
    logic [N-1:0]   Ack;
    logic           Q_IsFull = 1'b0;
    logic [W-1:0]   Q_Data_In;
    logic           Q_InputValid;
    logic           Busy;
    arb_state_e     dbg_state;

    logic [W-1:0] dat [N];

    always_comb begin
        for (int i = 0; i < N; i++) Req_Data[i*W +: W] = dat[i];
    end

    queue_write_arbiter #(
        .NUM_REQ   (N),
        .WIDTH     (W),
        .MAX_BURST (MAXB)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Req          (Req),
        .Lock         (Lock),
        .Req_Data     (Req_Data),
        .Ack          (Ack),
        .Q_IsFull     (Q_IsFull),
        .Q_Data_In    (Q_Data_In),
        .Q_InputValid (Q_InputValid),
        .Busy         (Busy),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a one-word buffer, a round-robin pointer and an
    // optional burst owner with a count of words it has been granted.
    bit           m_valid, n_valid;
    logic [W-1:0] m_data, n_data;
    int           m_last, n_last;
    int           m_owner, n_owner;
    int           m_cnt, n_cnt;
    logic [N-1:0] e_ack;

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_last  = N - 1;
        m_owner = -1;
        m_cnt   = 0;
    endtask

    // Drive inputs for one cycle (called just after a falling edge), then
    // compare DUT outputs with the model and compute the model's next state.
    task automatic apply(input logic [N-1:0] req, input logic [N-1:0] lock, input logic full);
        bit room, cont;
        int w;
        Req      = req;
        Lock     = lock;
        Q_IsFull = full;
        #1;
        room = !m_valid || !full;
        cont = (m_owner >= 0) && req[m_owner] && lock[m_owner];
        w    = -1;
        if (room) begin
            if (cont) w = m_owner;
            else begin
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
                end
            end
        end
        e_ack = '0;
        if (w >= 0) e_ack[w] = 1'b1;

        check("ack", W'(Ack), W'(e_ack));
        check("q_valid", W'(Q_InputValid), W'(m_valid && !full));
        check("busy", W'(Busy), W'(m_valid));
        check("q_data", Q_Data_In, m_data);
        check("burst_state", W'(dbg_state == BURST), W'(m_owner >= 0));

        n_valid = m_valid;
        n_data  = m_data;
        n_last  = m_last;
        n_owner = m_owner;
        n_cnt   = m_cnt;
        if (w >= 0) begin
            n_valid = 1;
            n_data  = dat[w];
            n_last  = w;
            if (cont) begin
                n_cnt = m_cnt + 1;
                if (n_cnt == MAXB) begin
                    n_owner = -1;
                    n_cnt   = 0;
                end
            end else if (lock[w] && MAXB > 1) begin
                n_owner = w;
                n_cnt   = 1;
            end else begin
                n_owner = -1;
                n_cnt   = 0;
            end
        end else begin
            if (m_valid && !full) n_valid = 0;
            if (room && !cont) begin
                n_owner = -1;
                n_cnt   = 0;
            end
        end
    endtask

    task automatic tick();
        m_valid = n_valid;
        m_data  = n_data;
        m_last  = n_last;
        m_owner = n_owner;
        m_cnt   = n_cnt;
        @(negedge Clock);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("rst_ack", W'(Ack), '0);
        check("rst_q_valid", W'(Q_InputValid), '0);
        check("rst_busy", W'(Busy), '0);
        model_reset();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] lock, input logic full);
        apply(req, lock, full);
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] seq_a [5];
    logic [N-1:0] seq_b [6];
    logic [W-1:0] held;
    logic [N-1:0] cur_req, cur_lock, last_ack;

    initial begin
        seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_b = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        for (int i = 0; i < N; i++) dat[i] = 32'h100 * (i + 1);
        model_reset();
        @(negedge Clock);
        do_reset();

        // single request: Ack same cycle, queue write next cycle
        dat[0] = 32'hA;
        apply(4'b0001, '0, 1'b0);
        check("first_ack", W'(Ack), W'(4'b0001));
        tick();
        apply('0, '0, 1'b0);
        check("first_qv", W'(Q_InputValid), 32'd1);
        check("first_data", Q_Data_In, 32'hA);
        tick();

        // plain round-robin over all requesters
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) dat[i] = $urandom;
            apply(4'b1111, '0, 1'b0);
            check("rr_seq", W'(Ack), W'(seq_a[c]));
            tick();
        end

        // queue stall with requests pending, then release
        held = m_data;
        for (int c = 0; c < 5; c++) begin
            apply(4'b0110, '0, 1'b1);
            check("stall_ack", W'(Ack), '0);
            check("stall_data", Q_Data_In, held);
            tick();
        end
        apply(4'b0110, '0, 1'b0);
        check("release_ack", W'(Ack), W'(4'b0010));
        tick();
        step(4'b0110, '0, 1'b0);

        // locked burst capped at MAX_BURST
        do_reset();
        for (int c = 0; c < 6; c++) begin
            apply(4'b1111, 4'b0010, 1'b0);
            check("burst_seq", W'(Ack), W'(seq_b[c]));
            tick();
        end

        // burst owner leaves after two grants
        do_reset();
        step(4'b1111, 4'b0010, 1'b0);
        step(4'b1111, 4'b0010, 1'b0);
        step(4'b1111, 4'b0010, 1'b0);
        apply(4'b1101, 4'b0000, 1'b0);
        check("drop_ack", W'(Ack), W'(4'b0100));
        tick();
        check("drop_state", W'(dbg_state), W'(ARB));

        // reset mid-burst with the register full
        do_reset();
        step(4'b1111, 4'b0010, 1'b0);
        step(4'b1111, 4'b0010, 1'b0);
        step(4'b1111, 4'b0010, 1'b1);
        do_reset();
        apply(4'b1111, 4'b0000, 1'b0);
        check("post_rst_busy", W'(Busy), '0);
        check("post_rst_ack", W'(Ack), W'(4'b0001));
        tick();

        // random traffic: each requester holds its word until acked or
        // occasionally withdraws it
        do_reset();
        cur_req  = '0;
        cur_lock = '0;
        last_ack = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!cur_req[i] || last_ack[i]) begin
                    cur_req[i]  = ($urandom_range(0, 1) == 1);
                    cur_lock[i] = ($urandom_range(0, 2) == 0);
                    dat[i]      = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    cur_req[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    cur_lock[i] = ~cur_lock[i];
                end
            end
            apply(cur_req, cur_lock, $urandom_range(0, 3) == 0);
            last_ack = e_ack;
            tick();
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                cur_req  = '0;
                last_ack = '0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
